// File: rtl/bounds_table_dlk.sv
// Bounds table with round-robin replacement and a 2-stage "next bound above base" check pipeline.
// Optional saturating violation counter enabled by defining DLK_VIOL_STATS_EN.
module bounds_table_dlk #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32,
    localparam int CUR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ins_valid_i,
    input  logic [ADDR_W-1:0] ins_addr_i,
    input  logic              rm_valid_i,
    input  logic [ADDR_W-1:0] rm_addr_i,
    input  logic              chk_valid_i,
    output logic              chk_ready_o,
    input  logic [ADDR_W-1:0] chk_base_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_viol_o,
    output logic              resp_hit_o,
    output logic [ADDR_W-1:0] resp_bound_o,
    output logic [CUR_W:0]    occupancy_o,
    output logic              evict_o,
    output logic [15:0]       viol_count_o
);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [CUR_W-1:0]  cursor;
    logic [DEPTH-1:0]  rm_hit;
    logic [DEPTH-1:0]  after_rm;
    logic [DEPTH-1:0]  next_valid;
    logic              ins_dup;
    logic              do_ins;
    logic              evict_next;
    logic [CUR_W:0]    next_occ;
    logic              stall;
    logic              lk_hit;
    logic [ADDR_W-1:0] lk_bound;
    logic              s1_valid;
    logic              s1_hit;
    logic [ADDR_W-1:0] s1_bound;
    logic [ADDR_W-1:0] s1_addr;

    assign stall       = resp_valid_o && !resp_ready_i;
    assign chk_ready_o = !stall;

    // Remove is applied before insert; a same-address insert is dropped so remove wins.
    always_comb begin
        ins_dup = 1'b0;
        rm_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] == ins_addr_i)) ins_dup = 1'b1;
            rm_hit[i] = rm_valid_i && valid[i] && (addr_mem[i] == rm_addr_i);
        end
        do_ins     = ins_valid_i && !ins_dup && !(rm_valid_i && (rm_addr_i == ins_addr_i));
        after_rm   = valid & ~rm_hit;
        next_valid = after_rm;
        if (do_ins) next_valid[cursor] = 1'b1;
        evict_next = do_ins && after_rm[cursor];
        next_occ   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_occ = next_occ + {{CUR_W{1'b0}}, next_valid[i]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid       <= '0;
            cursor      <= '0;
            occupancy_o <= '0;
            evict_o     <= 1'b0;
        end else if (flush_i) begin
            valid       <= '0;
            cursor      <= '0;
            occupancy_o <= '0;
            evict_o     <= 1'b0;
        end else begin
            valid       <= next_valid;
            occupancy_o <= next_occ;
            evict_o     <= evict_next;
            if (do_ins) cursor <= cursor + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i && do_ins) addr_mem[cursor] <= ins_addr_i;
    end

    // Smallest valid entry strictly above the base, using the pre-update table.
    always_comb begin
        lk_hit   = 1'b0;
        lk_bound = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] > chk_base_i) && (!lk_hit || (addr_mem[i] < lk_bound))) begin
                lk_hit   = 1'b1;
                lk_bound = addr_mem[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s1_hit       <= 1'b0;
            s1_bound     <= '0;
            s1_addr      <= '0;
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_bound_o <= '0;
            resp_viol_o  <= 1'b0;
        end else if (flush_i) begin
            s1_valid     <= 1'b0;
            resp_valid_o <= 1'b0;
        end else if (!stall) begin
            s1_valid     <= chk_valid_i;
            s1_hit       <= lk_hit;
            s1_bound     <= lk_bound;
            s1_addr      <= chk_addr_i;
            resp_valid_o <= s1_valid;
            resp_hit_o   <= s1_hit;
            resp_bound_o <= s1_bound;
            resp_viol_o  <= s1_hit && (s1_addr >= s1_bound);
        end
    end

`ifdef DLK_VIOL_STATS_EN
    logic [15:0] viol_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            viol_count <= '0;
        end else if (flush_i) begin
            viol_count <= '0;
        end else if (resp_valid_o && resp_ready_i && resp_viol_o && (viol_count != 16'hFFFF)) begin
            viol_count <= viol_count + 16'd1;
        end
    end

    assign viol_count_o = viol_count;
`else
    assign viol_count_o = 16'd0;
`endif

endmodule
